sseg_display_ctrl: RTL

SSEG_DISPLAY_CTRL -- requirements
Module: sseg_display_ctrl

---
 rtl/sseg_pkg.sv | 55 +++++
 rtl/sseg_glyph_enc.sv | 44 ++++
 rtl/sseg_display_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_pkg
//  Description : Shared constants for the seven-segment display controller:
//                active-high glyph patterns, segment bit positions, the
//                active-low blank code and the supported digit maximum.
//  Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    // Largest number of digits the controller is built for.
    localparam int DIGITS_MAX = 8;

    // Segment bit positions inside a 7-bit glyph (bit0 = a ... bit6 = g).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-low code that turns every segment of a digit off.
    localparam logic [6:0] SEG_BLANK_N = 7'h7F;

    // Active-high glyph that lights nothing (undisplayable code).
    localparam logic [6:0] GLYPH_OFF = 7'h00;

    // Active-high glyphs for decimal digits.
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;

    // Active-high glyphs for the hexadecimal letters.
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // True when a 4-bit code is a legal BCD digit.
    function automatic logic is_bcd(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_glyph_enc.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_glyph_enc
//  Description : Combinational 4-bit code to active-high 7-segment glyph.
//                Codes 10..15 produce letters A b C d E F in hex mode and an
//                unlit glyph otherwise.
//  Ports       : code_i     - 4-bit digit code
//                hex_mode_i - 1 = hexadecimal decoding, 0 = BCD decoding
//                glyph_o    - active-high segments, bit0 = a ... bit6 = g
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_glyph_enc
    import sseg_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       hex_mode_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = GLYPH_OFF;
        case (code_i)
            4'h0: glyph_o = GLYPH_0;
            4'h1: glyph_o = GLYPH_1;
            4'h2: glyph_o = GLYPH_2;
            4'h3: glyph_o = GLYPH_3;
            4'h4: glyph_o = GLYPH_4;
            4'h5: glyph_o = GLYPH_5;
            4'h6: glyph_o = GLYPH_6;
            4'h7: glyph_o = GLYPH_7;
            4'h8: glyph_o = GLYPH_8;
            4'h9: glyph_o = GLYPH_9;
            4'hA: glyph_o = hex_mode_i ? GLYPH_A : GLYPH_OFF;
            4'hB: glyph_o = hex_mode_i ? GLYPH_B : GLYPH_OFF;
            4'hC: glyph_o = hex_mode_i ? GLYPH_C : GLYPH_OFF;
            4'hD: glyph_o = hex_mode_i ? GLYPH_D : GLYPH_OFF;
            4'hE: glyph_o = hex_mode_i ? GLYPH_E : GLYPH_OFF;
            4'hF: glyph_o = hex_mode_i ? GLYPH_F : GLYPH_OFF;
            default: glyph_o = GLYPH_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sseg_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_display_ctrl
//  Description : Multi-digit seven-segment display controller. Captures a
//                BCD/hex value and decimal points on load, decodes each digit,
//                applies leading-zero blanking and per-digit blinking, and
//                drives registered active-low segment/dp outputs. A sticky
//                flag records any non-BCD digit captured in BCD mode.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                load         - capture strobe for bcd_in / dp_in
//                bcd_in       - digit k at [4k+3:4k], digit 0 least significant
//                dp_in        - per-digit decimal point request
//                lz_blank_en  - leading-zero blanking enable
//                blink_en     - blink enable
//                blink_mask   - per-digit blink select
//                clr_invalid  - clears the sticky invalid flag
//                seg_n        - active-low segments, digit k at [7k+6:7k]
//                dp_n         - active-low decimal points
//                invalid      - sticky non-BCD capture flag
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_display_ctrl
    import sseg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25000000,
    parameter int HEX_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_blank_en,
    input  logic                  blink_en,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  clr_invalid,
    output logic [7*DIGITS-1:0]   seg_n,
    output logic [DIGITS-1:0]     dp_n,
    output logic                  invalid
);

    localparam int                CNT_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic              HEX_BIT  = (HEX_MODE != 0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0]   val_q;
    logic [DIGITS-1:0]     dpsh_q;
    logic                  shown_q;
    logic                  pend_q;       // bad capture waiting to reach invalid
    logic                  invalid_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  phase_q;
    logic [7*DIGITS-1:0]   seg_q;
    logic [DIGITS-1:0]     dpo_q;

    logic                  invalid_d;
    logic [CNT_W-1:0]      cnt_d;
    logic                  phase_d;
    logic [7*DIGITS-1:0]   seg_d;
    logic [DIGITS-1:0]     dpo_d;

    logic                  w_bad_in;
    logic                  w_set_now;
    logic [DIGITS-1:0]     w_lz;
    logic                  w_lead;
    logic                  w_blink_off;
    logic                  w_digit_off;
    logic [DIGITS-1:0][6:0] w_glyph;

    // ------------------------------------------------------------------
    // Per-digit glyph decoders working on the shadow value
    // ------------------------------------------------------------------
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        sseg_glyph_enc u_enc (
            .code_i     (val_q[4*k +: 4]),
            .hex_mode_i (HEX_BIT),
            .glyph_o    (w_glyph[k])
        );
    end

    // ------------------------------------------------------------------
    // Non-BCD detection on the incoming word (never in hex mode)
    // ------------------------------------------------------------------
    always_comb begin
        w_bad_in = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!is_bcd(bcd_in[4*k +: 4])) begin
                w_bad_in = 1'b1;
            end
        end
        if (HEX_BIT) begin
            w_bad_in = 1'b0;
        end
    end

    assign w_set_now = load & w_bad_in;

    // The set becomes visible one edge after capture, together with the
    // digits. A clear sampled on the same edge as a bad capture is ignored
    // so the flag never drops while a set is in flight.
    assign invalid_d = pend_q | (invalid_q & ~(clr_invalid & ~w_set_now));

    // ------------------------------------------------------------------
    // Blink timebase. It only advances once something has been captured,
    // so the first displayed frame always gets a full shown half-period.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!blink_en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (shown_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero scan from the most significant digit; digit 0 is
    // never a candidate.
    // ------------------------------------------------------------------
    always_comb begin
        w_lz   = '0;
        w_lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (w_lead && (val_q[4*k +: 4] == 4'd0) && !dpsh_q[k]) begin
                w_lz[k] = 1'b1;
            end else begin
                w_lead = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output composition: inversion plus OR of all blanking sources.
    // Undisplayable codes already decode to an unlit glyph.
    // ------------------------------------------------------------------
    always_comb begin
        seg_d       = '1;
        dpo_d       = '1;
        w_blink_off = 1'b0;
        w_digit_off = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            w_blink_off = blink_en & phase_q & blink_mask[k];
            w_digit_off = ~shown_q | w_blink_off | (lz_blank_en & w_lz[k]);
            seg_d[7*k +: 7] = w_digit_off ? SEG_BLANK_N : ~w_glyph[k];
            dpo_d[k]        = (~shown_q | w_blink_off) ? 1'b1 : ~dpsh_q[k];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q     <= '0;
            dpsh_q    <= '0;
            shown_q   <= 1'b0;
            pend_q    <= 1'b0;
            invalid_q <= 1'b0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            seg_q     <= '1;
            dpo_q     <= '1;
        end else begin
            if (load) begin
                val_q   <= bcd_in;
                dpsh_q  <= dp_in;
                shown_q <= 1'b1;
            end
            pend_q    <= w_set_now;
            invalid_q <= invalid_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            seg_q     <= seg_d;
            dpo_q     <= dpo_d;
        end
    end

    assign seg_n   = seg_q;
    assign dp_n    = dpo_q;
    assign invalid = invalid_q;

endmodule
`default_nettype wire
